// File: rtl/seg_pkg.sv
// ============================================================================
//  Module : seg_pkg
//  Brief  : Shared constants and buffer type for the 7-segment digit scanner.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BLANK_CODE = 4'b0000;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic       OTHER_RST  = 1'b1;

    // One complete display image: codes, glyph-set selects and blank flags.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  other_mask;
        logic [3:0]  blank_mask;
    } frame_t;

    localparam frame_t FRAME_RST = '{digits: 16'h0000, other_mask: 4'hF, blank_mask: 4'hF};

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_tick_div.sv
// ============================================================================
//  Module : clk_tick_div
//  Brief  : Free-running prescaler, one-cycle tick every DIV clocks.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_tick_div #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST_CNT);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_scanner.sv
// ============================================================================
//  Module : seg_scanner
//  Brief  : Double-buffered 4-digit anode scanner feeding seg_controller.
//           Optional per-digit blinking enabled by defining SEG_BLINK_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scanner
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  other_mask,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [3:0]  num,
    output logic        other,
    output logic        frame_done
);

    logic       tick;
    logic       boundary;
    logic [1:0] idx_q, idx_d;
    logic       pend_q, pend_d;
    frame_t     in_frame;
    frame_t     pend_buf_q, pend_buf_d;
    frame_t     act_buf_q, act_buf_d;
    logic [3:0] an_q, an_d;
    logic [3:0] num_q, num_d;
    logic       other_q, other_d;
    logic       slot_dark;
    logic       blink_dark;

    clk_tick_div #(
        .DIV (REFRESH_DIV)
    ) u_refresh_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign in_frame   = {digits, other_mask, blank_mask};
    assign boundary   = tick && (idx_q == 2'd3);
    // Decoded from flops only, so it is a clean single-cycle pulse.
    assign frame_done = boundary;

`ifdef SEG_BLINK_EN
    logic       blink_tick;
    logic       blink_phase_q, blink_phase_d;
    logic [3:0] pend_blink_q, pend_blink_d;
    logic [3:0] act_blink_q, act_blink_d;

    clk_tick_div #(
        .DIV (BLINK_DIV)
    ) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .tick (blink_tick)
    );

    always_comb begin
        blink_phase_d = blink_phase_q ^ blink_tick;
        pend_blink_d  = load ? blink_mask : pend_blink_q;
        act_blink_d   = act_blink_q;
        if (boundary && load) begin
            act_blink_d = blink_mask;
        end else if (boundary && pend_q) begin
            act_blink_d = pend_blink_q;
        end
        blink_dark = act_blink_q[idx_q] & blink_phase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_phase_q <= 1'b0;
            pend_blink_q  <= 4'b0000;
            act_blink_q   <= 4'b0000;
        end else begin
            blink_phase_q <= blink_phase_d;
            pend_blink_q  <= pend_blink_d;
            act_blink_q   <= act_blink_d;
        end
    end
`else
    logic unused_blink;

    assign blink_dark   = 1'b0;
    assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
`endif

    always_comb begin
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        pend_buf_d = load ? in_frame : pend_buf_q;
        act_buf_d  = act_buf_q;
        pend_d     = pend_q;
        // A load landing on the boundary bypasses the pending buffer.
        if (boundary && load) begin
            act_buf_d = in_frame;
            pend_d    = 1'b0;
        end else if (boundary && pend_q) begin
            act_buf_d = pend_buf_q;
            pend_d    = 1'b0;
        end else if (load) begin
            pend_d    = 1'b1;
        end

        slot_dark = act_buf_q.blank_mask[idx_q] | blink_dark;
        an_d      = slot_dark ? AN_OFF     : anode_for(idx_q);
        num_d     = slot_dark ? BLANK_CODE : act_buf_q.digits[{idx_q, 2'b00} +: 4];
        other_d   = slot_dark ? OTHER_RST  : act_buf_q.other_mask[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= 2'd0;
            pend_q     <= 1'b0;
            pend_buf_q <= FRAME_RST;
            act_buf_q  <= FRAME_RST;
            an_q       <= AN_OFF;
            num_q      <= BLANK_CODE;
            other_q    <= OTHER_RST;
        end else begin
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_buf_q <= pend_buf_d;
            act_buf_q  <= act_buf_d;
            an_q       <= an_d;
            num_q      <= num_d;
            other_q    <= other_d;
        end
    end

    assign an    = an_q;
    assign num   = num_q;
    assign other = other_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scanner.sv
// ============================================================================
//  Module : tb_seg_scanner
//  Brief  : Directed self-checking bench for seg_scanner (REFRESH_DIV=4).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scanner;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  other_mask = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  an;
    logic [3:0]  num;
    logic        other;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg_scanner #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits     (digits),
        .other_mask (other_mask),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .num        (num),
        .other      (other),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; used to model the blink phase.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called on a falling edge; strobes load for one cycle.
    task automatic do_load(input logic [15:0] d, input logic [3:0] om,
                           input logic [3:0] bm, input logic [3:0] km);
        digits     = d;
        other_mask = om;
        blank_mask = bm;
        blink_mask = km;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Returns on the falling edge inside the slot-3 tick cycle.
    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_seen", {15'd0, frame_done}, 16'd1);
    endtask

    // Returns on the first falling edge that shows slot 0 of the next frame.
    task automatic show_next_frame();
        wait_frame();
        @(negedge clk);
        @(negedge clk);
    endtask

    // Checks 16 cycles (4 slots x 4 cycles) starting at a slot-0 falling edge.
    task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] om,
                               input logic [3:0] bm, input logic [3:0] km);
        logic       ph;
        logic       dark;
        logic [3:0] exp_an;
        logic [3:0] exp_num;
        logic       exp_other;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
`ifdef SEG_BLINK_EN
                ph = (((cyc - 1) / BLINK_DIV) % 2) == 1;
`else
                ph = 1'b0;
`endif
                dark      = bm[s] | (km[s] & ph);
                exp_an    = dark ? 4'b1111 : ~(4'b0001 << s);
                exp_num   = dark ? 4'h0 : d[4*s +: 4];
                exp_other = dark ? 1'b1 : om[s];
                check($sformatf("%s_an_s%0d", tag, s), {12'd0, an}, {12'd0, exp_an});
                check($sformatf("%s_num_s%0d", tag, s), {12'd0, num}, {12'd0, exp_num});
                check($sformatf("%s_other_s%0d", tag, s), {15'd0, other}, {15'd0, exp_other});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_an", {12'd0, an}, 16'h000F);
        check("rst_num", {12'd0, num}, 16'h0000);
        check("rst_other", {15'd0, other}, 16'd1);
        check("rst_frame_done", {15'd0, frame_done}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Dark display, frame_done every 16 cycles.
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check("idle_an", {12'd0, an}, 16'h000F);
            check("idle_num", {12'd0, num}, 16'h0000);
            check("idle_other", {15'd0, other}, 16'd1);
            check("idle_frame_done", {15'd0, frame_done}, {15'd0, (k % 16) == 15});
        end

        // Basic scan after a boundary.
        do_load(16'h4321, 4'b0000, 4'b0000, 4'b0000);
        show_next_frame();
        check_frame("scan", 16'h4321, 4'b0000, 4'b0000, 4'b0000);

        // Two loads in one frame: last wins, old data until the boundary.
        do_load(16'h5678, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'h0009, 4'b0000, 4'b0000, 4'b0000);
        check("hold_s1_num", {12'd0, num}, 16'h0002);
        check("hold_s1_an", {12'd0, an}, 16'h000D);
        repeat (4) @(negedge clk);
        check("hold_s2_num", {12'd0, num}, 16'h0003);
        show_next_frame();
        check_frame("last_wins", 16'h0009, 4'b0000, 4'b0000, 4'b0000);

        // Load coincident with the slot-3 tick.
        wait_frame();
        do_load(16'hABCD, 4'b1010, 4'b0000, 4'b0000);
        check("coinc_pend", {15'd0, dut.pend_q}, 16'd0);
        @(negedge clk);
        check_frame("coinc", 16'hABCD, 4'b1010, 4'b0000, 4'b0000);

        // Blank and letter-set selects.
        do_load(16'h0005, 4'b0001, 4'b0100, 4'b0000);
        show_next_frame();
        check_frame("blank", 16'h0005, 4'b0001, 4'b0100, 4'b0000);

        // Blink: dark only while the phase is high (only with SEG_BLINK_EN).
        do_load(16'h0087, 4'b0000, 4'b0000, 4'b0101);
        show_next_frame();
        check_frame("blink_a", 16'h0087, 4'b0000, 4'b0000, 4'b0101);
        check_frame("blink_b", 16'h0087, 4'b0000, 4'b0000, 4'b0101);

        // Reset asserted mid-slot 2 takes effect without a clock edge.
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        show_next_frame();
        repeat (9) @(negedge clk);
        check("pre_rst_an", {12'd0, an}, 16'h000B);
        check("pre_rst_num", {12'd0, num}, 16'h0002);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_an", {12'd0, an}, 16'h000F);
        check("mid_rst_num", {12'd0, num}, 16'h0000);
        check("mid_rst_other", {15'd0, other}, 16'd1);
        check("mid_rst_frame_done", {15'd0, frame_done}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("post_rst_an", {12'd0, an}, 16'h000F);
            check("post_rst_frame_done", {15'd0, frame_done}, {15'd0, k == 15});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
